bcd_display_driver: RTL

- Output stage downstream of the phase controller. It consumes the controller's 2-bit phase code and the binary result of the computation stage.
- When phase enters 3 (BCD display), it captures the result and converts it to packed BCD with a sequential double-dabble (shift-add-3) engine.
- It then time-multiplexes the digits onto a 7-segment display with one-hot anode scanning and leading-zero blanking.
- Outside phase 3 the display is blank.

---
 rtl/bcd_display_driver_if.sv | 18 +
 rtl/bcd_display_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver_if.sv
// Bus between the phase controller / computation stage and the BCD display driver.
// The master side drives the phase code and the result. The slave side (the driver)
// returns conversion status, the packed BCD value and the 7-segment scan outputs.
interface bcd_display_driver_if #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
);
  logic [1:0]          phase;
  logic [DATA_W-1:0]   result;
  logic                busy;
  logic                bcd_valid;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;

  modport master (output phase, result, input busy, bcd_valid, bcd, an, seg);
  modport slave  (input phase, result, output busy, bcd_valid, bcd, an, seg);
endinterface

// File: rtl/bcd_display_driver.sv
// BCD display driver. When the phase code enters 3, it captures the binary result and
// converts it to packed BCD with a sequential double-dabble engine (one bit per clock).
// It then scans the digits onto a multiplexed 7-segment display and blanks leading zeros.
// Outside phase 3 the display is dark.
module bcd_display_driver #(
  parameter int DATA_W         = 16,
  parameter int DIGITS         = 5,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  bcd_display_driver_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t            state;
  logic [1:0]        prev_phase;
  logic [DATA_W-1:0] shift_reg;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  bcd_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  ref_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic              busy_q;
  logic              valid_q;

  logic              in_disp;
  logic              start;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  nxt_scr;
  logic [DATA_W-1:0] nxt_sh;

  assign in_disp = (bus.phase == 2'd3);
  // Rising edge into phase 3 only; holding phase 3 does not restart the conversion.
  assign start   = in_disp && (prev_phase != 2'd3);

  // One double-dabble step: add 3 to each nibble >= 5, then shift {scratch, shift} left by 1.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    {nxt_scr, nxt_sh} = {adj, shift_reg} << 1;
  end

  // Control FSM, conversion datapath and scan counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_phase <= 2'd0;
      shift_reg  <= '0;
      scratch    <= '0;
      bcd_q      <= '0;
      bit_cnt    <= '0;
      ref_cnt    <= '0;
      scan_idx   <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      prev_phase <= bus.phase;
      case (state)
        IDLE: begin
          ref_cnt  <= '0;
          scan_idx <= '0;
          if (start) begin
            shift_reg <= bus.result;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy_q    <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          ref_cnt  <= '0;
          scan_idx <= '0;
          if (!in_disp) begin
            // Abandon the partial conversion. bcd keeps its previous value.
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            scratch   <= nxt_scr;
            shift_reg <= nxt_sh;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bcd_q   <= nxt_scr;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              state   <= SHOW;
            end
          end
        end
        SHOW: begin
          if (!in_disp) begin
            valid_q  <= 1'b0;
            ref_cnt  <= '0;
            scan_idx <= '0;
            state    <= IDLE;
          end else if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt  <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  logic [DIGITS-1:0] lead_nz;
  logic              running;
  logic [3:0]        sel_digit;
  logic              sel_lead;
  logic              blank;
  logic [6:0]        seg_ah;
  logic [DIGITS-1:0] an_ah;

  // lead_nz[i]: some digit at position i or above is non-zero (leading-zero mask).
  always_comb begin
    running = 1'b0;
    lead_nz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      running    = running | (|bcd_q[4*i +: 4]);
      lead_nz[i] = running;
    end
  end

  // Select the scanned digit and decode it to active-high segments {g,f,e,d,c,b,a}.
  always_comb begin
    sel_digit = 4'd0;
    sel_lead  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_digit = bcd_q[4*i +: 4];
        sel_lead  = lead_nz[i];
      end
    end
    blank = (scan_idx != '0) && !sel_lead;
    case (sel_digit)
      4'd0:    seg_ah = 7'b0111111;
      4'd1:    seg_ah = 7'b0000110;
      4'd2:    seg_ah = 7'b1011011;
      4'd3:    seg_ah = 7'b1001111;
      4'd4:    seg_ah = 7'b1100110;
      4'd5:    seg_ah = 7'b1101101;
      4'd6:    seg_ah = 7'b1111101;
      4'd7:    seg_ah = 7'b0000111;
      4'd8:    seg_ah = 7'b1111111;
      4'd9:    seg_ah = 7'b1101111;
      default: seg_ah = 7'b0000000;
    endcase
    an_ah = DIGITS'(1) << scan_idx;
    if (blank) seg_ah = 7'b0000000;
    if (state != SHOW) begin
      seg_ah = 7'b0000000;
      an_ah  = '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.seg       = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
  assign bus.an        = SEG_ACTIVE_LOW ? ~an_ah  : an_ah;
endmodule
